// File: rtl/fifo_rd_stream_adapter_pkg.sv
// Shared definitions for the FIFO read-side stream adapter: default word width,
// skid depth, the occupancy type and the signed occupancy helper.
package fifo_rd_stream_adapter_pkg;

  localparam int DEFAULT_DATA_SIZE = 8;
  localparam int DEPTH             = 2;

  typedef logic [1:0] count_t;

  // Signed so that an impossible underflow shows up as a negative value
  // instead of wrapping to 3.
  function automatic logic signed [2:0] occ_sum(input count_t cnt,
                                                input logic   add,
                                                input logic   sub);
    logic signed [2:0] s_cnt;
    logic signed [2:0] s_add;
    logic signed [2:0] s_sub;
    s_cnt = $signed({1'b0, cnt});
    s_add = $signed({2'b00, add});
    s_sub = $signed({2'b00, sub});
    return s_cnt + s_add - s_sub;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// FIFO read port plus output valid/ready stream. The master modport is the
// adapter's view; the slave modport is the FIFO/consumer environment's view.
interface fifo_rd_stream_adapter_if
  import fifo_rd_stream_adapter_pkg::*;
#(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE
);

  logic                 r_empty;
  logic                 r_en;
  logic [DATA_SIZE-1:0] r_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [DATA_SIZE-1:0] m_data;

  modport master (
    input  r_empty, r_data, m_ready,
    output r_en, m_valid, m_data
  );

  modport slave (
    output r_empty, r_data, m_ready,
    input  r_en, m_valid, m_data
  );

endinterface

// File: rtl/fifo_rd_stream_adapter_skid_buffer_2.sv
// Two-entry in-order skid buffer; head slot is the output word.
// FIFO_RD_ADAPTER_DATA_CLR_EN: zero vacated slots and gate the head to 0 when empty.
module skid_buffer_2
  import fifo_rd_stream_adapter_pkg::*;
#(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_SIZE-1:0] din,
  output logic [DATA_SIZE-1:0] head,
  output count_t               count
);

  logic [DATA_SIZE-1:0] head_q;
  logic [DATA_SIZE-1:0] tail_q;
  count_t               count_q;
  logic signed [2:0]    count_nxt;

  assign count_nxt = occ_sum(count_q, push, pop);
  assign count     = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_nxt[1:0];

      if (push && ((count_q == 2'd0) || ((count_q == 2'd1) && pop)))
        head_q <= din;
      else if (pop && (count_q == 2'd2))
        head_q <= tail_q;
`ifdef FIFO_RD_ADAPTER_DATA_CLR_EN
      else if (pop && (count_q == 2'd1))
        head_q <= '0;
`endif

      // Full-with-pop-and-push cannot occur under the credit rule, but the
      // tail still tracks it so the buffer stays a correct FIFO on its own.
      if (push && (((count_q == 2'd1) && !pop) || ((count_q == 2'd2) && pop)))
        tail_q <= din;
`ifdef FIFO_RD_ADAPTER_DATA_CLR_EN
      else if (pop && (count_q == 2'd2))
        tail_q <= '0;
`endif
    end
  end

`ifdef FIFO_RD_ADAPTER_DATA_CLR_EN
  assign head = (count_q != 2'd0) ? head_q : '0;
`else
  assign head = head_q;
`endif

  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    (!count_nxt[2] && (count_nxt[1:0] <= 2'(DEPTH))));

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// FIFO r_en/r_empty read port to first-word-fall-through valid/ready stream.
// FIFO_RD_ADAPTER_DATA_CLR_EN: m_data forced to 0 while m_valid is low.
module fifo_rd_stream_adapter
  import fifo_rd_stream_adapter_pkg::*;
#(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE
) (
  input  logic                     r_clk,
  input  logic                     rrst_n,
  fifo_rd_stream_adapter_if.master bus
);

  count_t            count;
  logic              inflight;
  logic              pop;
  logic signed [2:0] occ;

  assign bus.m_valid = (count != 2'd0);
  assign pop         = bus.m_valid & bus.m_ready;

  // Credit: words held plus the one arriving from RAM, less the one leaving,
  // must leave room for the word this read will deliver.
  assign occ      = occ_sum(count, inflight, pop);
  assign bus.r_en = rrst_n & ~bus.r_empty & (occ < 3'sd2);

  // ---- RAM read latency stage: inflight marks r_data valid this cycle ----
  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n)
      inflight <= 1'b0;
    else
      inflight <= bus.r_en;
  end

  // ---- output stage: 2-entry skid buffer ----
  skid_buffer_2 #(
    .DATA_SIZE (DATA_SIZE)
  ) u_skid (
    .clk   (r_clk),
    .rst_n (rrst_n),
    .push  (inflight),
    .pop   (pop),
    .din   (bus.r_data),
    .head  (bus.m_data),
    .count (count)
  );

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed and randomized-ready bench for fifo_rd_stream_adapter with a FIFO/RAM model.
module tb_fifo_rd_stream_adapter;
  import fifo_rd_stream_adapter_pkg::*;

  localparam int DW = 8;

  logic r_clk  = 1'b0;
  logic rrst_n = 1'b1;
  always #5 r_clk = ~r_clk;

  fifo_rd_stream_adapter_if #(.DATA_SIZE(DW)) bus ();

  fifo_rd_stream_adapter #(.DATA_SIZE(DW)) dut (
    .r_clk  (r_clk),
    .rrst_n (rrst_n),
    .bus    (bus.master)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_pops   = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic          r_pend     = 1'b0;
  logic [DW-1:0] pend       = '0;
  logic          hold_empty = 1'b0;
  logic          s_ren, s_valid;
  logic [DW-1:0] s_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs for the current cycle, sample outputs, advance the FIFO model.
  task automatic sample(input logic rdy);
    bus.r_data  = r_pend ? pend : DW'('hEE);
    bus.m_ready = rdy;
    bus.r_empty = hold_empty || (fifo_q.size() == 0);
    #1;
    s_ren   = bus.r_en;
    s_valid = bus.m_valid;
    s_data  = bus.m_data;
    if (bus.r_empty) check_eq("ren_while_empty", 32'(s_ren), 32'd0);
    r_pend = 1'b0;
    if (s_ren && (fifo_q.size() > 0)) begin
      pend = fifo_q.pop_front();
      exp_q.push_back(pend);
      r_pend = 1'b1;
    end
    if (s_valid && rdy) begin
      n_pops++;
      check_eq("beat_has_word", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check_eq("order", 32'(s_data), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic step(input logic rdy);
    @(posedge r_clk);
    #1;
    sample(rdy);
  endtask

  initial begin
    int ren_cnt, ren_run, ren_max, vld_run, vld_max, beats, p0;
    logic [DW-1:0] first_beat;

    bus.r_empty = 1'b0;
    bus.r_data  = '0;
    bus.m_ready = 1'b0;
    #2 rrst_n = 1'b0;

    // Reset state with a non-empty FIFO
    fifo_q = '{8'hA1, 8'hB2};
    repeat (3) @(posedge r_clk);
    #2;
    check_eq("rst_ren", 32'(bus.r_en), 32'd0);
    check_eq("rst_valid", 32'(bus.m_valid), 32'd0);
    check_eq("rst_data", 32'(bus.m_data), 32'd0);
    @(posedge r_clk);
    #1 rrst_n = 1'b1;
    sample(1'b1);
    check_eq("rel_c0_ren", 32'(s_ren), 32'd1);
    step(1'b1);
    check_eq("rel_c1_valid", 32'(s_valid), 32'd0);
    step(1'b1);
    check_eq("rel_c2_valid", 32'(s_valid), 32'd1);
    check_eq("rel_c2_data", 32'(s_data), 32'hA1);
    repeat (3) step(1'b1);
    check_eq("rel_drained", 32'(exp_q.size()), 32'd0);
    check_eq("rel_idle_valid", 32'(s_valid), 32'd0);

    // Streaming 0x10..0x17 with m_ready held high
    for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(8'h10 + i));
    ren_cnt = 0; ren_run = 0; ren_max = 0; vld_run = 0; vld_max = 0; beats = 0;
    for (int c = 0; c < 14; c++) begin
      step(1'b1);
      ren_cnt += int'(s_ren);
      ren_run  = s_ren ? ren_run + 1 : 0;
      vld_run  = s_valid ? vld_run + 1 : 0;
      if (ren_run > ren_max) ren_max = ren_run;
      if (vld_run > vld_max) vld_max = vld_run;
      if (s_valid) begin
        check_eq("stream_data", 32'(s_data), 32'(8'h10 + beats));
        beats++;
      end
    end
    check_eq("stream_ren_total", 32'(ren_cnt), 32'd8);
    check_eq("stream_ren_run", 32'(ren_max), 32'd8);
    check_eq("stream_vld_run", 32'(vld_max), 32'd8);

    // Backpressure: 4 words, consumer stalled
    for (int i = 0; i < 4; i++) fifo_q.push_back(DW'(8'h20 + i));
    ren_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b0);
      ren_cnt += int'(s_ren);
      if (c >= 2) begin
        check_eq("bp_valid_held", 32'(s_valid), 32'd1);
        check_eq("bp_data_stable", 32'(s_data), 32'h20);
      end
    end
    check_eq("bp_ren_pulses", 32'(ren_cnt), 32'd2);
    p0 = n_pops; vld_run = 0; vld_max = 0;
    for (int c = 0; c < 7; c++) begin
      step(1'b1);
      vld_run = s_valid ? vld_run + 1 : 0;
      if (vld_run > vld_max) vld_max = vld_run;
    end
    check_eq("bp_beats", 32'(n_pops - p0), 32'd4);
    check_eq("bp_no_gaps", 32'(vld_max), 32'd4);

    // Empty boundary: one word then FIFO stays empty
    fifo_q.push_back(8'h5A);
    ren_cnt = 0; p0 = n_pops; first_beat = '0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1);
      ren_cnt += int'(s_ren);
      if (s_valid) first_beat = s_data;
    end
    check_eq("empty_ren_pulses", 32'(ren_cnt), 32'd1);
    check_eq("empty_beats", 32'(n_pops - p0), 32'd1);
    check_eq("empty_beat_data", 32'(first_beat), 32'h5A);
    check_eq("empty_valid_low", 32'(s_valid), 32'd0);
`ifdef FIFO_RD_ADAPTER_DATA_CLR_EN
    check_eq("empty_data_idle", 32'(s_data), 32'h00);
`else
    check_eq("empty_data_idle", 32'(s_data), 32'h5A);
`endif

    // Mid-operation reset with a word held and a read in flight
    for (int i = 0; i < 4; i++) fifo_q.push_back(DW'(8'h30 + i));
    step(1'b0);
    step(1'b0);
    step(1'b0);
    check_eq("mr_pre_valid", 32'(s_valid), 32'd1);
    rrst_n = 1'b0;
    #1;
    check_eq("mr_async_valid", 32'(bus.m_valid), 32'd0);
    check_eq("mr_async_ren", 32'(bus.r_en), 32'd0);
    check_eq("mr_async_data", 32'(bus.m_data), 32'd0);
    fifo_q.delete();
    exp_q.delete();
    r_pend = 1'b0;
    repeat (2) @(posedge r_clk);
    fifo_q = '{8'h40, 8'h41};
    #1 rrst_n = 1'b1;
    sample(1'b1);
    p0 = n_pops; first_beat = '0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1);
      if (s_valid && (n_pops - p0 == 1)) first_beat = s_data;
    end
    check_eq("mr_first_beat", 32'(first_beat), 32'h40);
    check_eq("mr_beats", 32'(n_pops - p0), 32'd2);

    // Random m_ready and FIFO-empty gaps over 1000 words
    for (int i = 0; i < 1000; i++) fifo_q.push_back(DW'(i * 7 + 3));
    p0 = n_pops;
    for (int c = 0; c < 20000 && (n_pops - p0) < 1000; c++) begin
      hold_empty = ($urandom_range(0, 3) == 0);
      step(1'($urandom_range(0, 1)));
    end
    hold_empty = 1'b0;
    check_eq("rand_word_count", 32'(n_pops - p0), 32'd1000);
    check_eq("rand_sb_empty", 32'(exp_q.size()), 32'd0);
    check_eq("rand_fifo_empty", 32'(fifo_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
